fetch_ctrl: RTL and testbench

- Fetch-side initiator for the single-cycle-latency instruction memory port.
- Owns the PC and drives the memory's address, read-enable and NOP-request lines.
- Tags each returned word with its PC and a valid bit.
- Handles stalls, branch/jump redirects with wrong-path squash, and fault detection, so the decode stage sees an aligned {pc, instr, valid} stream.

---
 rtl/fetch_ctrl.sv | 59 +++++
 tb/tb_fetch_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, drives the 1-cycle imem port and tags returned words with pc/valid/fault
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_en_o,
  output logic        imem_nop_o,
  input  logic [31:0] imem_instr_i,
  input  logic        imem_nop_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic [1:0]  fault_o
);
  localparam logic [31:0] LIMIT = 32'(IMEM_WORDS * 4);
  logic [31:0] pc;
  logic        valid_q;
  logic        started;
  logic        in_range;
  always_comb begin
    in_range    = pc < LIMIT;
    imem_addr_o = pc;
    instr_o     = imem_instr_i;
    valid_o     = valid_q & ~imem_nop_i;
    imem_en_o   = started & ~redirect_i & ~stall_i & in_range;
    imem_nop_o  = ~started | redirect_i | (~stall_i & ~in_range);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_PC;
      pc_o    <= RESET_PC;
      valid_q <= 1'b0;
      fault_o <= 2'b00;
      started <= 1'b0;
    end else if (!started) begin
      started <= 1'b1;
    end else if (redirect_i) begin
      pc         <= {redirect_pc_i[31:2], 2'b00};
      pc_o       <= pc;
      valid_q    <= 1'b0;
      fault_o[0] <= fault_o[0] | (|redirect_pc_i[1:0]);
    end else if (!stall_i) begin
      if (in_range) begin
        pc      <= pc + 32'd4;
        pc_o    <= pc;
        valid_q <= 1'b1;
      end else begin
        valid_q    <= 1'b0;
        fault_o[1] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch_ctrl against a 1-cycle behavioural imem
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic [31:0] imem_addr_o;
  logic        imem_en_o;
  logic        imem_nop_o;
  logic [31:0] imem_instr_i;
  logic        imem_nop_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic [1:0]  fault_o;
  int          n_checks = 0;
  int          n_fail = 0;
  fetch_ctrl dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_en_o(imem_en_o),
    .imem_nop_o(imem_nop_o), .imem_instr_i(imem_instr_i), .imem_nop_i(imem_nop_i),
    .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .fault_o(fault_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_instr_i <= 32'h0000_0013;
      imem_nop_i   <= 1'b1;
    end else if (imem_en_o) begin
      imem_instr_i <= 32'h1000_0000 + imem_addr_o;
      imem_nop_i   <= 1'b0;
    end else if (imem_nop_o) begin
      imem_instr_i <= 32'h0000_0013;
      imem_nop_i   <= 1'b1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic out(input string tag, input logic [31:0] pc, input logic v, input logic [31:0] ins);
    check({tag, " pc_o"}, pc_o, pc);
    check({tag, " valid"}, 32'(valid_o), 32'(v));
    check({tag, " instr"}, instr_o, ins);
  endtask
  initial begin
    @(negedge clk);
    check("rst en", 32'(imem_en_o), 32'd0);
    check("rst nop", 32'(imem_nop_o), 32'd1);
    check("rst addr", imem_addr_o, 32'h0);
    check("rst fault", 32'(fault_o), 32'd0);
    out("rst", 32'h0, 1'b0, 32'h13);
    rst = 1'b1;
    #1 check("start gap en", 32'(imem_en_o), 32'd0);
    @(negedge clk);
    check("first en", 32'(imem_en_o), 32'd1);
    check("addr0", imem_addr_o, 32'h0);
    @(negedge clk);
    check("addr4", imem_addr_o, 32'h4);
    out("w0", 32'h0, 1'b1, 32'h1000_0000);
    @(negedge clk);
    check("addr8", imem_addr_o, 32'h8);
    out("w4", 32'h4, 1'b1, 32'h1000_0004);
    @(negedge clk);
    out("w8", 32'h8, 1'b1, 32'h1000_0008);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall en", 32'(imem_en_o), 32'd0);
      check("stall nop", 32'(imem_nop_o), 32'd0);
      check("stall addr", imem_addr_o, 32'hC);
      out("stall", 32'h8, 1'b1, 32'h1000_0008);
    end
    stall_i = 1'b0;
    #1 check("resume en", 32'(imem_en_o), 32'd1);
    @(negedge clk);
    out("wC", 32'hC, 1'b1, 32'h1000_000C);
    check("addr10", imem_addr_o, 32'h10);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    #1 check("redir nop", 32'(imem_nop_o), 32'd1);
    check("redir en", 32'(imem_en_o), 32'd0);
    @(negedge clk);
    redirect_i = 1'b0;
    out("squash", 32'h10, 1'b0, 32'h13);
    check("redir addr", imem_addr_o, 32'h40);
    @(negedge clk);
    out("w40", 32'h40, 1'b1, 32'h1000_0040);
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    #1 check("stredir nop", 32'(imem_nop_o), 32'd1);
    @(negedge clk);
    redirect_i = 1'b0;
    check("stredir valid", 32'(valid_o), 32'd0);
    check("stredir addr", imem_addr_o, 32'h100);
    check("stredir en", 32'(imem_en_o), 32'd0);
    @(negedge clk);
    check("stredir hold", imem_addr_o, 32'h100);
    check("stredir hold v", 32'(valid_o), 32'd0);
    stall_i = 1'b0;
    @(negedge clk);
    out("w100", 32'h100, 1'b1, 32'h1000_0100);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h22;
    @(negedge clk);
    redirect_i = 1'b0;
    check("mis addr", imem_addr_o, 32'h20);
    check("mis fault", 32'(fault_o), 32'd1);
    @(negedge clk);
    out("w20", 32'h20, 1'b1, 32'h1000_0020);
    check("mis sticky", 32'(fault_o), 32'd1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h7F8;
    @(negedge clk);
    redirect_i = 1'b0;
    @(negedge clk);
    check("addr7FC", imem_addr_o, 32'h7FC);
    @(negedge clk);
    out("w7FC", 32'h7FC, 1'b1, 32'h1000_07FC);
    check("oor addr", imem_addr_o, 32'h800);
    check("oor en", 32'(imem_en_o), 32'd0);
    check("oor nop", 32'(imem_nop_o), 32'd1);
    @(negedge clk);
    check("oor valid", 32'(valid_o), 32'd0);
    check("oor fault", 32'(fault_o), 32'd3);
    @(negedge clk);
    check("oor hold", imem_addr_o, 32'h800);
    check("oor hold v", 32'(valid_o), 32'd0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0;
    @(negedge clk);
    redirect_i = 1'b0;
    @(negedge clk);
    out("recover", 32'h0, 1'b1, 32'h1000_0000);
    check("fault sticky", 32'(fault_o), 32'd3);
    rst = 1'b0;
    #1 check("mid rst pc_o", pc_o, 32'h0);
    check("mid rst valid", 32'(valid_o), 32'd0);
    check("mid rst fault", 32'(fault_o), 32'd0);
    check("mid rst addr", imem_addr_o, 32'h0);
    check("mid rst nop", 32'(imem_nop_o), 32'd1);
    @(negedge clk);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h80;
    rst = 1'b1;
    @(negedge clk);
    check("first redir en", 32'(imem_en_o), 32'd0);
    check("first redir nop", 32'(imem_nop_o), 32'd1);
    @(negedge clk);
    redirect_i = 1'b0;
    check("first redir addr", imem_addr_o, 32'h80);
    check("first redir v", 32'(valid_o), 32'd0);
    @(negedge clk);
    out("w80", 32'h80, 1'b1, 32'h1000_0080);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
